// File: rtl/alu_pkg.sv
// alu_pkg: word width, opcode type and opcode encodings shared by the ALU slice
package alu_pkg;
  localparam int DEF_WIDTH = 16;
  typedef logic [4:0] op_t;
  localparam op_t OP_ADD   = 5'b00000;
  localparam op_t OP_SUB   = 5'b00001;
  localparam op_t OP_AND   = 5'b00010;
  localparam op_t OP_OR    = 5'b00011;
  localparam op_t OP_XOR   = 5'b00100;
  localparam op_t OP_NOT   = 5'b00101;
  localparam op_t OP_NEG   = 5'b00110;
  localparam op_t OP_SHL   = 5'b00111;
  localparam op_t OP_SHR   = 5'b01000;
  localparam op_t OP_SRA   = 5'b01001;
  localparam op_t OP_SLT   = 5'b01010;
  localparam op_t OP_SLTU  = 5'b01011;
  localparam op_t OP_MUL   = 5'b01100;
  localparam op_t OP_PASSX = 5'b01101;
  localparam op_t OP_PASSY = 5'b01110;
  localparam op_t OP_EQ    = 5'b01111;
endpackage

// File: rtl/alu_if.sv
// alu_if: operand/opcode bundle into the ALU and its registered result back out
interface alu_if
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  op_t              ALUop;
  logic [WIDTH-1:0] z;
  modport master (output X, Y, ALUop, input z);
  modport slave (input X, Y, ALUop, output z);
endinterface

// File: rtl/alu_shifter.sv
// alu_shifter: SHL/SHR/SRA with saturation once the shift amount reaches the word width
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  op_t              mode,
  output logic [WIDTH-1:0] r
);
  localparam int SW = $clog2(WIDTH);
  logic             ovf;
  logic [SW-1:0]    sh;
  logic [WIDTH-1:0] fill;
  assign ovf  = |(y >> SW);
  assign sh   = y[SW-1:0];
  assign fill = {WIDTH{x[WIDTH-1]}};
  // an out-of-range amount empties the word, except SRA which floods it with the sign bit
  always_comb
    r = mode == OP_SHL ? (ovf ? '0 : x << sh) :
        mode == OP_SHR ? (ovf ? '0 : x >> sh) :
        mode == OP_SRA ? (ovf ? fill : WIDTH'($signed(x) >>> sh)) : '0;
endmodule

// File: rtl/alu.sv
// alu: 16-bit execute-stage ALU with a single registered result
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic  clk,
  input logic  rst_n,
  alu_if.slave bus
);
  logic [WIDTH-1:0] sh_r;
  logic [WIDTH-1:0] f;
  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .x    (bus.X),
    .y    (bus.Y),
    .mode (bus.ALUop),
    .r    (sh_r)
  );
  // result for every opcode; reserved codes yield zero
  always_comb begin
    f = '0;
    case (bus.ALUop)
      OP_ADD:   f = bus.X + bus.Y;
      OP_SUB:   f = bus.X - bus.Y;
      OP_AND:   f = bus.X & bus.Y;
      OP_OR:    f = bus.X | bus.Y;
      OP_XOR:   f = bus.X ^ bus.Y;
      OP_NOT:   f = ~bus.X;
      OP_NEG:   f = '0 - bus.X;
      OP_SHL, OP_SHR, OP_SRA: f = sh_r;
      OP_SLT:   f = {{(WIDTH-1){1'b0}}, $signed(bus.X) < $signed(bus.Y)};
      OP_SLTU:  f = {{(WIDTH-1){1'b0}}, bus.X < bus.Y};
      OP_MUL:   f = bus.X * bus.Y;
      OP_PASSX: f = bus.X;
      OP_PASSY: f = bus.Y;
      OP_EQ:    f = {{(WIDTH-1){1'b0}}, bus.X == bus.Y};
      default:  f = '0;
    endcase
  end
  // output register, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bus.z <= '0;
    else bus.z <= f;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vectors against hand-computed ALU results
module tb_alu;
  import alu_pkg::*;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  alu_if #(.WIDTH(16)) bus ();
  alu #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input string tag, input op_t op, input logic [15:0] x, input logic [15:0] y,
                     input logic [15:0] exp);
    @(negedge clk);
    bus.ALUop = op;
    bus.X     = x;
    bus.Y     = y;
    @(posedge clk);
    #1 check(tag, bus.z, exp);
  endtask
  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.ALUop = OP_PASSX;
    bus.X  = 16'h5555;
    bus.Y  = 16'h0000;
    repeat (2) @(posedge clk);
    #1 check("reset_hold", bus.z, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    run("add_first", OP_ADD, 16'h0003, 16'h0004, 16'h0007);
    run("add_wrap", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000);
    run("sub_wrap", OP_SUB, 16'h0000, 16'h0001, 16'hFFFF);
    run("neg", OP_NEG, 16'h0001, 16'h1234, 16'hFFFF);
    run("mul_wrap", OP_MUL, 16'h0100, 16'h0100, 16'h0000);
    run("mul", OP_MUL, 16'h0003, 16'h0005, 16'h000F);
    run("and", OP_AND, 16'hF0F0, 16'hFF00, 16'hF000);
    run("or", OP_OR, 16'hF0F0, 16'hFF00, 16'hFFF0);
    run("xor", OP_XOR, 16'hF0F0, 16'hFF00, 16'h0FF0);
    run("not", OP_NOT, 16'hF0F0, 16'hFF00, 16'h0F0F);
    run("shl15", OP_SHL, 16'h0001, 16'd15, 16'h8000);
    run("shl16", OP_SHL, 16'h0001, 16'd16, 16'h0000);
    run("shl3", OP_SHL, 16'h00F1, 16'd3, 16'h0788);
    run("shr15", OP_SHR, 16'h8000, 16'd15, 16'h0001);
    run("shr16", OP_SHR, 16'hFFFF, 16'd16, 16'h0000);
    run("sra4", OP_SRA, 16'h8000, 16'd4, 16'hF800);
    run("sra20", OP_SRA, 16'h8000, 16'd20, 16'hFFFF);
    run("sra_pos20", OP_SRA, 16'h7000, 16'd20, 16'h0000);
    run("sra_big", OP_SRA, 16'h8000, 16'h0100, 16'hFFFF);
    run("slt", OP_SLT, 16'hFFFF, 16'h0001, 16'h0001);
    run("sltu", OP_SLTU, 16'hFFFF, 16'h0001, 16'h0000);
    run("slt_false", OP_SLT, 16'h0001, 16'hFFFF, 16'h0000);
    run("sltu_true", OP_SLTU, 16'h0001, 16'hFFFF, 16'h0001);
    run("eq", OP_EQ, 16'h1234, 16'h1234, 16'h0001);
    run("eq_false", OP_EQ, 16'h1234, 16'h1235, 16'h0000);
    run("passx", OP_PASSX, 16'hCAFE, 16'hBEEF, 16'hCAFE);
    run("passy", OP_PASSY, 16'hCAFE, 16'hBEEF, 16'hBEEF);
    run("pipe_add", OP_ADD, 16'h1000, 16'h0234, 16'h1234);
    run("pipe_sub", OP_SUB, 16'h1000, 16'h0001, 16'h0FFF);
    run("pipe_rsv", 5'b10101, 16'hFFFF, 16'hFFFF, 16'h0000);
    run("rsv_1f", 5'b11111, 16'h1234, 16'h5678, 16'h0000);
    run("pre_reset", OP_PASSY, 16'h0000, 16'hBEEF, 16'hBEEF);
    @(negedge clk);
    bus.ALUop = OP_ADD;
    bus.X     = 16'h0003;
    bus.Y     = 16'h0004;
    #2 rst_n = 1'b0;
    #1 check("reset_async", bus.z, 16'h0000);
    @(posedge clk);
    #1 check("reset_edge", bus.z, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    run("reset_release", OP_ADD, 16'h0003, 16'h0004, 16'h0007);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
